// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter: one registered 2:1 MUX level per shift-amount bit,
// with a valid/ready handshake and a user tag that rides along with each operand.

module barrel_shifter_stage #(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int LEVELS = 5,
    parameter int K      = 0
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              adv,
    input  logic              prevValid,
    input  logic [WIDTH-1:0]  prevData,
    input  logic [LEVELS-1:0] prevAmt,
    input  logic              prevFill,
    input  logic [1:0]        prevMode,
    input  logic [TAG_W-1:0]  prevTag,
    output logic              nextValid,
    output logic [WIDTH-1:0]  nextData,
    output logic [LEVELS-1:0] nextAmt,
    output logic              nextFill,
    output logic [1:0]        nextMode,
    output logic [TAG_W-1:0]  nextTag
);
    localparam int D = 1 << K;
    localparam logic [WIDTH-1:0] LOW_MASK  = {{(WIDTH-D){1'b0}}, {D{1'b1}}};
    localparam logic [WIDTH-1:0] HIGH_MASK = {{D{1'b1}}, {(WIDTH-D){1'b0}}};

    logic [WIDTH-1:0] shifted;

    // SRA needs no special case: its fill bit already holds the original sign.
    always_comb begin
        shifted = prevData;
        if (prevAmt[K]) begin
            case (prevMode)
                2'b00:        shifted = (prevData << D) | (prevFill ? LOW_MASK : '0);
                2'b01, 2'b10: shifted = (prevData >> D) | (prevFill ? HIGH_MASK : '0);
                default:      shifted = (prevData << D) | (prevData >> (WIDTH - D));
            endcase
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            nextValid <= 1'b0;
            nextData  <= '0;
            nextAmt   <= '0;
            nextFill  <= 1'b0;
            nextMode  <= '0;
            nextTag   <= '0;
        end else if (adv) begin
            nextValid <= prevValid;
            nextData  <= shifted;
            nextAmt   <= prevAmt;
            nextFill  <= prevFill;
            nextMode  <= prevMode;
            nextTag   <= prevTag;
        end
    end
endmodule

module barrel_shifter_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int TAG_W  = 4,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              InValid,
    output logic              InReady,
    input  logic [WIDTH-1:0]  In,
    input  logic [LEVELS-1:0] ShiftAmount,
    input  logic              ShiftIn,
    input  logic [1:0]        Mode,
    input  logic [TAG_W-1:0]  InTag,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  Out,
    output logic [TAG_W-1:0]  OutTag
);
    localparam logic [1:0] MODE_SRA = 2'b10;

    // Index 0 is the issue side; index k+1 is the register of stage k.
    logic [LEVELS:0]                 vldPipe;
    logic [LEVELS:0][WIDTH-1:0]      dataPipe;
    logic [LEVELS:0][LEVELS-1:0]     amtPipe;
    logic [LEVELS:0]                 fillPipe;
    logic [LEVELS:0][1:0]            modePipe;
    logic [LEVELS:0][TAG_W-1:0]      tagPipe;
    logic                            adv;

    assign vldPipe[0]  = InValid;
    assign dataPipe[0] = In;
    assign amtPipe[0]  = ShiftAmount;
    assign fillPipe[0] = (Mode == MODE_SRA) ? In[WIDTH-1] : ShiftIn;
    assign modePipe[0] = Mode;
    assign tagPipe[0]  = InTag;

    // Whole pipe moves in lockstep; a held result freezes every stage, bubbles included.
    assign OutValid = vldPipe[LEVELS];
    assign Out      = dataPipe[LEVELS];
    assign OutTag   = tagPipe[LEVELS];
    assign InReady  = OutReady | ~OutValid;
    assign adv      = InReady;

    for (genvar k = 0; k < LEVELS; k++) begin : gStage
        barrel_shifter_stage #(
            .WIDTH(WIDTH), .TAG_W(TAG_W), .LEVELS(LEVELS), .K(k)
        ) uStage (
            .Clock    (Clock),
            .ResetN   (ResetN),
            .adv      (adv),
            .prevValid(vldPipe[k]),
            .prevData (dataPipe[k]),
            .prevAmt  (amtPipe[k]),
            .prevFill (fillPipe[k]),
            .prevMode (modePipe[k]),
            .prevTag  (tagPipe[k]),
            .nextValid(vldPipe[k+1]),
            .nextData (dataPipe[k+1]),
            .nextAmt  (amtPipe[k+1]),
            .nextFill (fillPipe[k+1]),
            .nextMode (modePipe[k+1]),
            .nextTag  (tagPipe[k+1])
        );
    end

    // Control fields have no consumer past the last stage.
    logic unusedTail;
    assign unusedTail = ^{amtPipe[LEVELS], fillPipe[LEVELS], modePipe[LEVELS]};
endmodule
